mem_burst_slave: RTL and testbench

MEM_BURST_SLAVE -- requirements
Module: mem_burst_slave

---
 rtl/mem_burst_pkg.sv | 25 ++
 rtl/ram_blk_sp.sv | 23 ++
 rtl/mem_burst_slave.sv | 168 ++++++++++++++++
 tb/tb_mem_burst_slave.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_burst_pkg.sv
// Shared types and helpers for the wrapping-burst memory slave.
package mem_burst_pkg;

  localparam int unsigned LINE_WORDS     = 4;
  localparam int unsigned LOG2LINE_WORDS = 2;
  localparam int unsigned MAX_BYTES      = 32;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StDelay   = 3'd1,
    StGnt     = 3'd2,
    StWrBurst = 3'd3,
    StRdBurst = 3'd4
  } state_e;

  // Odd parity per byte: bit i makes byte i plus its parity bit hold an odd number of ones.
  function automatic logic [MAX_BYTES-1:0] odd_byte_par(input logic [8*MAX_BYTES-1:0] data);
    logic [MAX_BYTES-1:0] par;
    for (int i = 0; i < MAX_BYTES; i++) begin
      par[i] = ~^data[8*i +: 8];
    end
    return par;
  endfunction

endpackage

// File: rtl/ram_blk_sp.sv
// Single-port RAM block with synchronous read; contents are not reset.
module ram_blk_sp #(
  parameter int unsigned WIDTH = 72,
  parameter int unsigned DEPTH = 8192,
  parameter int unsigned ADDRW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ADDRW-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_burst_slave.sv
// Four-word wrapping burst memory slave with programmable grant delay.
// Optional write-parity checker enabled by defining MEM_BURST_PAR_CHECK_EN.
module mem_burst_slave
  import mem_burst_pkg::*;
#(
  parameter int unsigned LOG2BYTEWIDTH = 3,
  parameter int unsigned ADDRWIDTH     = 29,
  parameter int unsigned PARWIDTH      = 8,
  parameter int unsigned LOG2MEMSIZE   = 16,
  parameter int unsigned GNT_DELAY     = 2,
  localparam int unsigned DATAWIDTH    = 8 * (2 ** LOG2BYTEWIDTH)
) (
  input  logic                 clk,
  input  logic                 reset_l,
  input  logic                 mem_req,
  input  logic                 mem_write,
  input  logic [ADDRWIDTH-1:0] mem_addr,
  output logic                 mem_gnt,
  input  logic [DATAWIDTH-1:0] mem_wr_data,
  input  logic [PARWIDTH-1:0]  mem_wr_par,
  output logic [DATAWIDTH-1:0] mem_rd_data,
  output logic [PARWIDTH-1:0]  mem_rd_par,
  output logic                 par_err
);

  localparam int unsigned WordAw  = LOG2MEMSIZE - LOG2BYTEWIDTH;
  localparam int unsigned LineAw  = WordAw - LOG2LINE_WORDS;
  localparam int unsigned RamW    = DATAWIDTH + PARWIDTH;
  localparam int unsigned DlyLast = (GNT_DELAY > 0) ? GNT_DELAY - 1 : 0;

  state_e                    state_q, state_d;
  logic                      write_q, write_d;
  logic [LineAw-1:0]         line_q, line_d;
  logic [LOG2LINE_WORDS-1:0] start_q, start_d;
  logic [LOG2LINE_WORDS-1:0] beat_q, beat_d;
  logic [3:0]                dly_q, dly_d;

  logic                      ram_we;
  logic [LOG2LINE_WORDS-1:0] ram_off;
  logic [WordAw-1:0]         ram_addr;
  logic [RamW-1:0]           ram_wdata;
  logic [RamW-1:0]           ram_rdata;
  logic                      rd_valid;

  // Bits above LOG2MEMSIZE alias; word-offset bits below the line are folded in here.
  logic unused_addr;
  assign unused_addr = ^mem_addr;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= StIdle;
      write_q <= 1'b0;
      line_q  <= '0;
      start_q <= '0;
      beat_q  <= '0;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      line_q  <= line_d;
      start_q <= start_d;
      beat_q  <= beat_d;
      dly_q   <= dly_d;
    end
  end

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    line_d  = line_q;
    start_d = start_q;
    beat_d  = beat_q;
    dly_d   = dly_q;
    unique case (state_q)
      StIdle: begin
        dly_d = '0;
        if (mem_req) begin
          write_d = mem_write;
          line_d  = mem_addr[LOG2MEMSIZE-1 -: LineAw];
          start_d = mem_addr[LOG2BYTEWIDTH +: LOG2LINE_WORDS];
          state_d = (GNT_DELAY > 0) ? StDelay : StGnt;
        end
      end
      StDelay: begin
        if (dly_q == 4'(DlyLast)) begin
          dly_d   = '0;
          state_d = StGnt;
        end else begin
          dly_d = dly_q + 4'd1;
        end
      end
      StGnt: begin
        // Write word 0 is taken in the grant cycle, so the write burst resumes at beat 1.
        beat_d  = write_q ? LOG2LINE_WORDS'(1) : '0;
        state_d = write_q ? StWrBurst : StRdBurst;
      end
      StWrBurst, StRdBurst: begin
        beat_d = beat_q + LOG2LINE_WORDS'(1);
        if (beat_q == LOG2LINE_WORDS'(LINE_WORDS - 1)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_gnt  = 1'b0;
    ram_we   = 1'b0;
    rd_valid = 1'b0;
    ram_off  = start_q + beat_q;
    unique case (state_q)
      StGnt: begin
        mem_gnt = 1'b1;
        ram_we  = write_q;
        ram_off = start_q;
      end
      StWrBurst: ram_we = 1'b1;
      StRdBurst: begin
        // Read address runs one beat ahead of the data on the bus.
        rd_valid = 1'b1;
        ram_off  = start_q + beat_q + LOG2LINE_WORDS'(1);
      end
      default: ;
    endcase
    ram_addr    = {line_q, ram_off};
    ram_wdata   = {mem_wr_par, mem_wr_data};
    mem_rd_data = rd_valid ? ram_rdata[DATAWIDTH-1:0] : '0;
    mem_rd_par  = rd_valid ? ram_rdata[RamW-1:DATAWIDTH] : '0;
  end

  ram_blk_sp #(
    .WIDTH(RamW),
    .DEPTH(2 ** WordAw),
    .ADDRW(WordAw)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

`ifdef MEM_BURST_PAR_CHECK_EN
  localparam int unsigned ParInW = 8 * MAX_BYTES;

  logic                 par_err_q;
  logic [MAX_BYTES-1:0] par_calc;
  logic                 unused_par;

  assign par_calc   = odd_byte_par(ParInW'(mem_wr_data));
  assign unused_par = ^par_calc;

  // Bad words are still stored; the flag only records that one was seen.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      par_err_q <= 1'b0;
    end else if (ram_we && (mem_wr_par != par_calc[PARWIDTH-1:0])) begin
      par_err_q <= 1'b1;
    end
  end

  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_burst_slave.sv
// Self-checking bench for mem_burst_slave: table-driven bursts plus hand-written corner sequences.
module tb_mem_burst_slave;

  logic        clk;
  logic        reset_l;
  logic        mem_req;
  logic        mem_write;
  logic [28:0] mem_addr;
  logic [63:0] mem_wr_data;
  logic [7:0]  mem_wr_par;

  logic        gnt_a, gnt_b;
  logic [63:0] rd_data_a, rd_data_b;
  logic [7:0]  rd_par_a, rd_par_b;
  logic        par_err_a, par_err_b;

  int n_vec = 0;
  int n_err = 0;
  logic [71:0] exp_q [$];

  typedef struct {
    bit          wr;
    logic [28:0] addr;
    logic [255:0] d;
    logic [255:0] exp;
  } vec_t;

  vec_t vecs [7];

  mem_burst_slave #(.GNT_DELAY(3)) dut_a (
    .clk        (clk),
    .reset_l    (reset_l),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_gnt    (gnt_a),
    .mem_wr_data(mem_wr_data),
    .mem_wr_par (mem_wr_par),
    .mem_rd_data(rd_data_a),
    .mem_rd_par (rd_par_a),
    .par_err    (par_err_a)
  );

  mem_burst_slave #(.GNT_DELAY(0)) dut_b (
    .clk        (clk),
    .reset_l    (reset_l),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_gnt    (gnt_b),
    .mem_wr_data(mem_wr_data),
    .mem_wr_par (mem_wr_par),
    .mem_rd_data(rd_data_b),
    .mem_rd_par (rd_par_b),
    .par_err    (par_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] opar(input logic [63:0] w);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) begin
      r[b] = 1'b1;
      for (int i = 0; i < 8; i++) r[b] = r[b] ^ w[8*b+i];
    end
    return r;
  endfunction

  function automatic logic [31:0] parpk(input logic [255:0] d);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = opar(d[64*k +: 64]);
    return r;
  endfunction

  function automatic logic [255:0] pk(input logic [63:0] w0, input logic [63:0] w1,
                                      input logic [63:0] w2, input logic [63:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Entered at posedge+1 of the request cycle; returns at the negedge of the grant cycle.
  task automatic wait_gnt(output int lat);
    bit found = 1'b0;
    lat = -1;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (gnt_a === 1'b1) begin
        found = 1'b1;
        lat   = i;
      end else begin
        @(posedge clk);
        #1;
        if (i == 0) mem_req = 1'b0;
      end
    end
    mem_req = 1'b0;
  endtask

  task automatic run_burst(input bit wr, input logic [28:0] addr, input logic [255:0] d,
                           input logic [255:0] exp_d, input logic [31:0] exp_p);
    int lat;
    logic [71:0] e;
    mem_write   = wr;
    mem_addr    = addr;
    mem_wr_data = d[63:0];
    mem_wr_par  = opar(d[63:0]);
    mem_req     = 1'b1;
    if (!wr) begin
      for (int k = 0; k < 4; k++) exp_q.push_back({exp_d[64*k +: 64], exp_p[8*k +: 8]});
    end
    wait_gnt(lat);
    check("gnt_latency", 64'(lat), 64'd4);
    if (lat < 0) begin
      exp_q.delete();
    end else if (wr) begin
      for (int k = 1; k < 4; k++) begin
        @(posedge clk);
        #1;
        mem_wr_data = d[64*k +: 64];
        mem_wr_par  = opar(d[64*k +: 64]);
        @(negedge clk);
        check("wr_single_gnt", 64'(gnt_a), 64'd0);
      end
    end else begin
      check("rd_zero_in_gnt", rd_data_a, 64'd0);
      for (int k = 0; k < 4; k++) begin
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        check("rd_beat_data", rd_data_a, e[71:8]);
        check("rd_beat_par", 64'(rd_par_a), 64'(e[7:0]));
        check("rd_single_gnt", 64'(gnt_a), 64'd0);
      end
      @(posedge clk);
      @(negedge clk);
      check("rd_zero_after", {rd_data_a[63:8], rd_par_a}, 64'd0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat, cnt;
    int ga [$];
    int gb [$];
    logic exp_pe;
`ifdef MEM_BURST_PAR_CHECK_EN
    exp_pe = 1'b1;
`else
    exp_pe = 1'b0;
`endif

    vecs[0] = '{1'b1, 29'h100,   pk(64'h11, 64'h22, 64'h33, 64'h44), '0};
    vecs[1] = '{1'b0, 29'h100,   '0, pk(64'h11, 64'h22, 64'h33, 64'h44)};
    vecs[2] = '{1'b0, 29'h110,   '0, pk(64'h33, 64'h44, 64'h11, 64'h22)};
    vecs[3] = '{1'b1, 29'h10020, pk(64'hA1, 64'hB2, 64'hC3, 64'hD4), '0};
    vecs[4] = '{1'b0, 29'h00020, '0, pk(64'hA1, 64'hB2, 64'hC3, 64'hD4)};
    vecs[5] = '{1'b1, 29'h1F8,   pk(64'hDEAD_BEEF_0000_0005, 64'h0123_4567_89AB_CDE6,
                                    64'h8000_0000_0000_0007, 64'hFFFF_0000_FFFF_0008), '0};
    // Started at word 3, so line word 0 holds the second written word.
    vecs[6] = '{1'b0, 29'h1E8,   '0, pk(64'h8000_0000_0000_0007, 64'hFFFF_0000_FFFF_0008,
                                        64'hDEAD_BEEF_0000_0005, 64'h0123_4567_89AB_CDE6)};

    reset_l     = 1'b0;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    mem_wr_par  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_gnt", 64'(gnt_a), 64'd0);
    check("reset_rd_data", rd_data_a, 64'd0);
    check("reset_rd_par", 64'(rd_par_a), 64'd0);
    check("reset_par_err", 64'(par_err_a), 64'd0);
    check("reset_gnt_b", 64'(gnt_b), 64'd0);
    @(posedge clk);
    #1;
    reset_l = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < 7; v++) begin
      run_burst(vecs[v].wr, vecs[v].addr, vecs[v].d, vecs[v].exp, parpk(vecs[v].exp));
    end

    // Request held high: grant latency and back-to-back write spacing for both delays.
    mem_write   = 1'b1;
    mem_addr    = 29'h800;
    mem_wr_data = '0;
    mem_wr_par  = 8'hFF;
    mem_req     = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (gnt_a) ga.push_back(c);
      if (gnt_b) gb.push_back(c);
      @(posedge clk);
      #1;
    end
    mem_req = 1'b0;
    check("held_a_gnt_count", 64'(ga.size()), 64'd4);
    check("held_b_gnt_count", 64'(gb.size()), 64'd6);
    if (ga.size() >= 2) begin
      check("held_a_first", 64'(ga[0]), 64'd4);
      check("held_a_spacing", 64'(ga[1] - ga[0]), 64'd8);
    end
    if (gb.size() >= 2) begin
      check("held_b_first", 64'(gb[0]), 64'd1);
      check("held_b_spacing", 64'(gb[1] - gb[0]), 64'd5);
    end
    repeat (12) @(posedge clk);
    #1;

    // Reset in the second beat of a write aborts the rest of the burst.
    run_burst(1'b1, 29'h200, pk(64'h0A, 64'h0B, 64'h0C, 64'h0D), '0, '0);
    mem_write   = 1'b1;
    mem_addr    = 29'h200;
    mem_wr_data = 64'hF0;
    mem_wr_par  = opar(64'hF0);
    mem_req     = 1'b1;
    wait_gnt(lat);
    check("abort_gnt_latency", 64'(lat), 64'd4);
    @(posedge clk);
    #1;
    mem_wr_data = 64'hF1;
    mem_wr_par  = opar(64'hF1);
    reset_l     = 1'b0;
    #2;
    reset_l     = 1'b1;
    @(negedge clk);
    check("abort_gnt_low", 64'(gnt_a), 64'd0);
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      mem_wr_data = 64'hF2 + 64'(c);
      @(negedge clk);
      if (gnt_a || gnt_b) cnt++;
    end
    check("abort_no_gnt", 64'(cnt), 64'd0);
    @(posedge clk);
    #1;
    run_burst(1'b0, 29'h200, '0, pk(64'hF0, 64'h0B, 64'h0C, 64'h0D),
              parpk(pk(64'hF0, 64'h0B, 64'h0C, 64'h0D)));

    // Bad parity on word 2 of a write.
    mem_write   = 1'b1;
    mem_addr    = 29'h300;
    mem_wr_data = '0;
    mem_wr_par  = 8'hFF;
    mem_req     = 1'b1;
    wait_gnt(lat);
    check("par_gnt_latency", 64'(lat), 64'd4);
    check("par_err_at_T", 64'(par_err_a), 64'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    mem_wr_par = 8'hFE;
    @(negedge clk);
    check("par_err_at_T2", 64'(par_err_a), 64'd0);
    @(posedge clk);
    #1;
    mem_wr_par = 8'hFF;
    @(negedge clk);
    check("par_err_rise", 64'(par_err_a), 64'(exp_pe));
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("par_err_sticky", 64'(par_err_a), 64'(exp_pe));
    @(posedge clk);
    #1;
    run_burst(1'b0, 29'h300, '0, '0, 32'hFF_FE_FF_FF);
    check("par_err_hold", 64'(par_err_a), 64'(exp_pe));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
